rv32i_dii_injector: RTL and testbench

- Core-side responder for RVFI-DII direct instruction injection; receives instruction packets from the DPI socket driver and feeds them to the rv32i_core fetch path.
- Buffers packets in a small FIFO and tracks injected-but-unretired instructions against the RVFI retire strobe.
- On an end-of-trace command, drains and raises a halt request plus a done pulse for the bench, which replies with unhalt.

---
 rtl/rv32i_dii_pkg.sv | 15 +
 rtl/rv32i_dii_fifo.sv | 45 ++++
 rtl/rv32i_dii_injector.sv | 115 +++++++++++
 tb/tb_rv32i_dii_injector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_dii_pkg.sv
// Shared types and constants for the RVFI-DII instruction injector.
package rv32i_dii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INJECT,
    ST_DRAIN,
    ST_DONE
  } dii_state_e;

  localparam logic        DII_CMD_INSN = 1'b1;
  localparam logic        DII_CMD_END  = 1'b0;
  localparam logic [31:0] RV_NOP       = 32'h0000_0013;

endpackage

// File: rtl/rv32i_dii_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible whenever not empty.
module rv32i_dii_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rv32i_dii_injector.sv
// RVFI-DII injector: buffers injected instructions, tracks retirement, halts at end-of-trace.
// Optional RV32I_DII_STATS_EN adds inj_count/ret_count statistics outputs.
module rv32i_dii_injector
  import rv32i_dii_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dii_valid,
  output logic             dii_ready,
  input  logic             dii_cmd,
  input  logic [31:0]      dii_insn,
  input  logic             fetch_req,
  output logic             fetch_valid,
  output logic [31:0]      fetch_insn,
  input  logic             retire_valid,
  input  logic             unhalt,
  output logic             halt_req,
  output logic             trace_done,
  output logic [CNT_W-1:0] outstanding,
  output logic             protocol_err
`ifdef RV32I_DII_STATS_EN
  ,
  output logic [31:0]      inj_count,
  output logic [31:0]      ret_count
`endif
);

  dii_state_e       state_q, state_d;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_rdata;
  logic             accept, push, pop, restart;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;

  assign dii_ready   = !fifo_full && (state_q == ST_IDLE || state_q == ST_INJECT);
  assign accept      = dii_valid && dii_ready;
  assign push        = accept && (dii_cmd == DII_CMD_INSN);
  assign fetch_valid = !fifo_empty;
  assign fetch_insn  = fifo_empty ? RV_NOP : fifo_rdata;
  assign pop         = fetch_req && !fifo_empty;
  assign restart     = (state_q == ST_DONE) && unhalt;

  rv32i_dii_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .push  (push),
    .wdata (dii_insn),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (dii_cmd == DII_CMD_INSN) ? ST_INJECT : ST_DRAIN;
      ST_INJECT: if (accept && dii_cmd == DII_CMD_END) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && outstanding == '0) state_d = ST_DONE;
      ST_DONE:   if (unhalt) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = outstanding;
    err_d = protocol_err;
    case ({pop, retire_valid})
      2'b10: if (&outstanding) err_d = 1'b1; else cnt_d = outstanding + 1'b1;
      2'b01: if (outstanding == '0) err_d = 1'b1; else cnt_d = outstanding - 1'b1;
      default: ;
    endcase
    if (restart)
      cnt_d = '0;
  end

  // halt_req/trace_done are registered from the next state so they align with DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      outstanding  <= '0;
      protocol_err <= 1'b0;
      halt_req     <= 1'b0;
      trace_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      outstanding  <= cnt_d;
      protocol_err <= err_d;
      halt_req     <= (state_d == ST_DONE);
      trace_done   <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

`ifdef RV32I_DII_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      inj_count <= '0;
      ret_count <= '0;
    end else begin
      if (pop && !(&inj_count))
        inj_count <= inj_count + 1'b1;
      if (retire_valid && !(&ret_count))
        ret_count <= ret_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_dii_injector.sv
// Directed self-checking bench for rv32i_dii_injector.
module tb_rv32i_dii_injector;
  import rv32i_dii_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dii_valid = 1'b0;
  logic        dii_ready;
  logic        dii_cmd = 1'b1;
  logic [31:0] dii_insn = '0;
  logic        fetch_req = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_insn;
  logic        retire_valid = 1'b0;
  logic        unhalt = 1'b0;
  logic        halt_req;
  logic        trace_done;
  logic [7:0]  outstanding;
  logic        protocol_err;
`ifdef RV32I_DII_STATS_EN
  logic [31:0] inj_count;
  logic [31:0] ret_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_seq [8];

  always #5 clk = ~clk;

  rv32i_dii_injector #(
    .FIFO_DEPTH(8),
    .CNT_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dii_valid    (dii_valid),
    .dii_ready    (dii_ready),
    .dii_cmd      (dii_cmd),
    .dii_insn     (dii_insn),
    .fetch_req    (fetch_req),
    .fetch_valid  (fetch_valid),
    .fetch_insn   (fetch_insn),
    .retire_valid (retire_valid),
    .unhalt       (unhalt),
    .halt_req     (halt_req),
    .trace_done   (trace_done),
    .outstanding  (outstanding),
    .protocol_err (protocol_err)
`ifdef RV32I_DII_STATS_EN
    ,
    .inj_count    (inj_count),
    .ret_count    (ret_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  initial begin
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check_eq("rst_ready", 32'(dii_ready), 32'd1);
    check_eq("rst_fvalid", 32'(fetch_valid), 32'd0);
    check_eq("rst_finsn", fetch_insn, 32'h0000_0013);
    check_eq("rst_halt", 32'(halt_req), 32'd0);
    check_eq("rst_done", 32'(trace_done), 32'd0);
    check_eq("rst_outst", 32'(outstanding), 32'd0);
    check_eq("rst_err", 32'(protocol_err), 32'd0);
    check_eq("rst_state", st(), 32'(ST_IDLE));

    // first packets: visible one cycle after accept
    dii_valid = 1'b1; dii_cmd = 1'b1; dii_insn = 32'h0010_0093;
    check_eq("t1_pre_fvalid", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("t1_fvalid", 32'(fetch_valid), 32'd1);
    check_eq("t1_finsn", fetch_insn, 32'h0010_0093);
    check_eq("t1_state", st(), 32'(ST_INJECT));
    dii_insn = 32'h0020_0113;
    tick();
    dii_valid = 1'b0;
    check_eq("t1_finsn2", fetch_insn, 32'h0010_0093);
    check_eq("t1_outst", 32'(outstanding), 32'd0);
    fetch_req = 1'b1;
    tick();
    check_eq("t1_pop1", fetch_insn, 32'h0020_0113);
    check_eq("t1_outst1", 32'(outstanding), 32'd1);
    tick();
    fetch_req = 1'b0;
    check_eq("t1_empty", 32'(fetch_valid), 32'd0);
    check_eq("t1_nop", fetch_insn, 32'h0000_0013);
    check_eq("t1_outst2", 32'(outstanding), 32'd2);
    retire_valid = 1'b1;
    tick();
    tick();
    retire_valid = 1'b0;
    check_eq("t1_retired", 32'(outstanding), 32'd0);

    // fill to full, overflow attempt, pop, wrap
    for (int i = 0; i < 8; i++) begin
      dii_valid = 1'b1; dii_insn = 32'h1000_0000 + 32'(i);
      check_eq("fill_ready", 32'(dii_ready), 32'd1);
      tick();
    end
    check_eq("full_ready", 32'(dii_ready), 32'd0);
    dii_insn = 32'hDEAD_BEEF;
    tick();
    dii_valid = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check_eq("pop_ready", 32'(dii_ready), 32'd1);
    check_eq("pop_head", fetch_insn, 32'h1000_0001);
    check_eq("pop_outst", 32'(outstanding), 32'd1);
    dii_valid = 1'b1; dii_insn = 32'h2000_0000;
    tick();
    dii_valid = 1'b0;
    check_eq("refull_ready", 32'(dii_ready), 32'd0);
    for (int i = 0; i < 7; i++) exp_seq[i] = 32'h1000_0001 + 32'(i);
    exp_seq[7] = 32'h2000_0000;
    fetch_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("wrap_seq", fetch_insn, exp_seq[i]);
      tick();
    end
    fetch_req = 1'b0;
    check_eq("wrap_empty", 32'(fetch_valid), 32'd0);
    check_eq("wrap_outst", 32'(outstanding), 32'd9);
    retire_valid = 1'b1;
    repeat (9) tick();
    retire_valid = 1'b0;
    check_eq("wrap_retired", 32'(outstanding), 32'd0);

    // retire at zero -> sticky error
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
    check_eq("err_outst", 32'(outstanding), 32'd0);
    check_eq("err_flag", 32'(protocol_err), 32'd1);

    // pop and retire in the same cycle
    dii_valid = 1'b1; dii_insn = 32'h0000_0A13;
    tick();
    dii_insn = 32'h0000_0B13;
    tick();
    dii_valid = 1'b0;
    fetch_req = 1'b1;
    tick();
    check_eq("pr_outst1", 32'(outstanding), 32'd1);
    retire_valid = 1'b1;
    tick();
    fetch_req = 1'b0;
    check_eq("pr_same", 32'(outstanding), 32'd1);
    tick();
    retire_valid = 1'b0;
    check_eq("pr_zero", 32'(outstanding), 32'd0);

    // drain sequence
    dii_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dii_insn = 32'h0030_0193 + 32'(i);
      tick();
    end
    dii_valid = 1'b0;
    fetch_req = 1'b1;
    repeat (3) tick();
    fetch_req = 1'b0;
    check_eq("dr_outst3", 32'(outstanding), 32'd3);
    dii_valid = 1'b1; dii_cmd = 1'b0;
    tick();
    dii_valid = 1'b0; dii_cmd = 1'b1;
    check_eq("dr_state", st(), 32'(ST_DRAIN));
    check_eq("dr_ready", 32'(dii_ready), 32'd0);
    check_eq("dr_halt", 32'(halt_req), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      retire_valid = (k % 2 == 0);
      tick();
      check_eq("dr_outst", 32'(outstanding), 32'(3 - k / 2));
      check_eq("dr_nodone", 32'(trace_done), 32'd0);
    end
    retire_valid = 1'b0;
    tick();
    check_eq("dn_state", st(), 32'(ST_DONE));
    check_eq("dn_pulse", 32'(trace_done), 32'd1);
    check_eq("dn_halt", 32'(halt_req), 32'd1);
`ifdef RV32I_DII_STATS_EN
    check_eq("dn_inj", inj_count, 32'd16);
`endif
    tick();
    check_eq("dn_pulse_off", 32'(trace_done), 32'd0);
    check_eq("dn_halt2", 32'(halt_req), 32'd1);
    tick();
    check_eq("dn_halt3", 32'(halt_req), 32'd1);

    // unhalt back to IDLE
    unhalt = 1'b1;
    tick();
    unhalt = 1'b0;
    check_eq("uh_halt", 32'(halt_req), 32'd0);
    check_eq("uh_state", st(), 32'(ST_IDLE));
    check_eq("uh_outst", 32'(outstanding), 32'd0);
    check_eq("uh_ready", 32'(dii_ready), 32'd1);
    check_eq("uh_nop", fetch_insn, 32'h0000_0013);
    check_eq("uh_err_kept", 32'(protocol_err), 32'd1);
`ifdef RV32I_DII_STATS_EN
    check_eq("uh_inj", inj_count, 32'd0);
    check_eq("uh_ret", ret_count, 32'd0);
`endif
    unhalt = 1'b1;
    tick();
    unhalt = 1'b0;
    check_eq("uh_ignored", st(), 32'(ST_IDLE));

    // reset mid-trace
    dii_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dii_insn = 32'h0040_0213 + 32'(i);
      tick();
    end
    dii_valid = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check_eq("mr_state", st(), 32'(ST_INJECT));
    check_eq("mr_outst", 32'(outstanding), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mr_fvalid", 32'(fetch_valid), 32'd0);
    check_eq("mr_nop", fetch_insn, 32'h0000_0013);
    check_eq("mr_outst0", 32'(outstanding), 32'd0);
    check_eq("mr_idle", st(), 32'(ST_IDLE));
    check_eq("mr_err", 32'(protocol_err), 32'd0);
`ifdef RV32I_DII_STATS_EN
    check_eq("mr_inj", inj_count, 32'd0);
    check_eq("mr_ret", ret_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
